ascon_reg_xbar: RTL and testbench



---
 rtl/ascon_reg_xbar.sv | 185 ++++++++++++++++++
 tb/tb_ascon_reg_xbar.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_reg_xbar.sv
// Register-bus demultiplexer: one upstream reg port to N_TARGETS downstream ports plus a
// local CSR window holding interrupt pending/mask and a saturating error counter.

package ascon_reg_pkg;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;

  typedef struct packed {
    logic [AddrW-1:0]   addr;
    logic               write;
    logic [DataW-1:0]   wdata;
    logic [DataW/8-1:0] wstrb;
    logic               valid;
  } reg_req_t;

  typedef struct packed {
    logic [DataW-1:0] rdata;
    logic             error;
    logic             ready;
  } reg_rsp_t;
endpackage

module ascon_reg_xbar
  import ascon_reg_pkg::*;
#(
  parameter int unsigned N_TARGETS      = 2,
  parameter int unsigned SEL_LSB        = 7,
  parameter int unsigned SEL_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  reg_req_t                  reg_req_i,
  output reg_rsp_t                  reg_rsp_o,
  output reg_req_t [N_TARGETS-1:0]  tgt_req_o,
  input  reg_rsp_t [N_TARGETS-1:0]  tgt_rsp_i,
  input  logic     [N_TARGETS-1:0]  intr_i,
  output logic                      intr_o
);

  localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned TgtIdxW  = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;

  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);
  localparam logic [SEL_W-1:0]    LocalSel    = '1;
  localparam logic [SEL_W-1:0]    NumTgt      = SEL_W'(N_TARGETS);

  typedef enum logic [1:0] {StIdle, StFwd, StLocal, StResp} state_e;

  state_e                 state_q;
  logic [TimeoutW-1:0]    cnt_q;
  logic [TgtIdxW-1:0]     tgt_idx_q;
  logic [1:0]             loc_off_q;
  logic                   loc_write_q;
  logic [N_TARGETS-1:0]   loc_wdata_q;

  logic [N_TARGETS-1:0]   intr_q;
  logic [N_TARGETS-1:0]   pending_q;
  logic [N_TARGETS-1:0]   mask_q;
  logic [CNT_W-1:0]       err_cnt_q;

  logic [SEL_W-1:0]       sel_in;
  logic [TgtIdxW-1:0]     tgt_idx_in;
  logic                   dec_err;
  reg_rsp_t               sel_rsp;
  logic                   timeout;
  logic                   err_evt;
  logic                   local_we;
  logic [N_TARGETS-1:0]   w1c_bits;
  logic                   mask_we;
  logic                   cnt_clr;
  logic [N_TARGETS-1:0]   intr_rise;
  logic [DataW-1:0]       local_rdata;

  assign sel_in     = reg_req_i.addr[SEL_LSB+SEL_W-1:SEL_LSB];
  assign tgt_idx_in = TgtIdxW'(sel_in);
  assign dec_err    = (sel_in >= NumTgt) && (sel_in != LocalSel);
  assign sel_rsp    = tgt_rsp_i[tgt_idx_q];

  // A ready arriving in the final counted cycle takes priority over the timeout.
  assign timeout = (state_q == StFwd) && !sel_rsp.ready && (cnt_q == TimeoutLast);
  assign err_evt = ((state_q == StIdle) && reg_req_i.valid && dec_err) || timeout;

  assign local_we  = (state_q == StLocal) && loc_write_q;
  assign w1c_bits  = (local_we && (loc_off_q == 2'd0)) ? loc_wdata_q : '0;
  assign mask_we   = local_we && (loc_off_q == 2'd1);
  assign cnt_clr   = local_we && (loc_off_q == 2'd2);
  assign intr_rise = intr_i & ~intr_q;

  always_comb begin
    local_rdata = '0;
    case (loc_off_q)
      2'd0:    local_rdata[N_TARGETS-1:0] = pending_q;
      2'd1:    local_rdata[N_TARGETS-1:0] = mask_q;
      2'd2:    local_rdata[CNT_W-1:0]     = err_cnt_q;
      default: local_rdata                = '0;
    endcase
  end

  // Request/response path: both upstream and downstream outputs are registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tgt_idx_q   <= '0;
      loc_off_q   <= '0;
      loc_write_q <= 1'b0;
      loc_wdata_q <= '0;
      tgt_req_o   <= '0;
      reg_rsp_o   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (reg_req_i.valid) begin
            tgt_idx_q   <= tgt_idx_in;
            loc_off_q   <= reg_req_i.addr[3:2];
            loc_write_q <= reg_req_i.write;
            loc_wdata_q <= reg_req_i.wdata[N_TARGETS-1:0];
            if (sel_in < NumTgt) begin
              state_q               <= StFwd;
              cnt_q                 <= '0;
              tgt_req_o[tgt_idx_in] <= reg_req_i;
            end else if (sel_in == LocalSel) begin
              state_q <= StLocal;
            end else begin
              state_q   <= StResp;
              reg_rsp_o <= '{rdata: '0, error: 1'b1, ready: 1'b1};
            end
          end
        end
        StFwd: begin
          if (sel_rsp.ready) begin
            state_q   <= StResp;
            tgt_req_o <= '0;
            reg_rsp_o <= '{rdata: sel_rsp.rdata, error: sel_rsp.error, ready: 1'b1};
          end else if (timeout) begin
            state_q   <= StResp;
            tgt_req_o <= '0;
            reg_rsp_o <= '{rdata: '0, error: 1'b1, ready: 1'b1};
          end else begin
            cnt_q <= cnt_q + TimeoutW'(1);
          end
        end
        StLocal: begin
          state_q   <= StResp;
          reg_rsp_o <= '{rdata: local_rdata, error: 1'b0, ready: 1'b1};
        end
        StResp: begin
          state_q   <= StIdle;
          reg_rsp_o <= '0;
        end
        default: begin
          state_q   <= StIdle;
          tgt_req_o <= '0;
          reg_rsp_o <= '0;
        end
      endcase
    end
  end

  // Local CSRs; a new interrupt edge overrides a same-cycle write-1-to-clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      intr_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      err_cnt_q <= '0;
      intr_o    <= 1'b0;
    end else begin
      intr_q    <= intr_i;
      pending_q <= (pending_q & ~w1c_bits) | intr_rise;
      if (mask_we) begin
        mask_q <= loc_wdata_q;
      end
      if (cnt_clr) begin
        err_cnt_q <= '0;
      end else if (err_evt && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
      intr_o <= |(pending_q & mask_q);
    end
  end

endmodule

// File: tb/tb_ascon_reg_xbar.sv
// Directed bench for ascon_reg_xbar: vector table of single accesses plus hand sequences
// for interrupts, counter saturation and reset during a forwarded access.

module tb_ascon_reg_xbar;
  import ascon_reg_pkg::*;

  logic                 clk;
  logic                 rst_i;
  reg_req_t             req;
  reg_rsp_t             reg_rsp_o;
  reg_req_t [1:0]       tgt_req_o;
  reg_rsp_t [1:0]       tgt_rsp;
  logic     [1:0]       intr;
  logic                 intr_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Target model: ready once valid has been seen for t_dly cycles (t_dly 0 = same cycle).
  int          t_dly;
  logic [31:0] t_rd;
  logic        t_err;
  int          vcnt [2];

  ascon_reg_xbar #(
    .N_TARGETS      (2),
    .SEL_LSB        (7),
    .SEL_W          (2),
    .TIMEOUT_CYCLES (8),
    .CNT_W          (4)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .reg_req_i (req),
    .reg_rsp_o (reg_rsp_o),
    .tgt_req_o (tgt_req_o),
    .tgt_rsp_i (tgt_rsp),
    .intr_i    (intr),
    .intr_o    (intr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      vcnt[i] <= tgt_req_o[i].valid ? vcnt[i] + 1 : 0;
    end
  end

  always_comb begin
    tgt_rsp = '0;
    for (int i = 0; i < 2; i++) begin
      if (tgt_req_o[i].valid && (vcnt[i] == t_dly)) begin
        tgt_rsp[i] = '{rdata: t_rd, error: t_err, ready: 1'b1};
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // One upstream transaction; lat is counted from the cycle the request is first presented.
  task automatic access(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int tv0, output int tv1);
    @(posedge clk); #1;
    req = '{addr: addr, write: wr, wdata: wd, wstrb: 4'hf, valid: 1'b1};
    lat = -1; tv0 = 0; tv1 = 0; rd = '0; er = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tgt_req_o[0].valid) tv0++;
      if (tgt_req_o[1].valid) tv1++;
      if (reg_rsp_o.ready) begin
        lat = i;
        rd  = reg_rsp_o.rdata;
        er  = reg_rsp_o.error;
        break;
      end
    end
    @(posedge clk); #1;
    req = '0;
    if (lat < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL access_timeout: addr 0x%0h got no ready, expected ready within 40", addr);
    end
  endtask

  task automatic rd_local(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    int          lat, tv0, tv1;
    access(addr, 1'b0, 32'h0, rd, er, lat, tv0, tv1);
    chk({name, "_rdata"}, 64'(rd), 64'(exp));
    chk({name, "_err"}, 64'(er), 64'h0);
  endtask

  task automatic wr_local(input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    logic        er;
    int          lat, tv0, tv1;
    access(addr, 1'b1, wd, rd, er, lat, tv0, tv1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    int          dly;
    logic [31:0] trd;
    logic        terr;
    int          lat;
    logic [31:0] rd;
    logic        chk_rd;
    logic        err;
    int          tv0;
    int          tv1;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, tv0, tv1;

    //          addr     wr  wdata         dly  trd           terr lat rd            chk err tv0 tv1
    vecs[0]  = '{32'h080, 0, 32'h0,        0,   32'h12345678, 0,   2,  32'h12345678, 1,  0,  0,  1};
    vecs[1]  = '{32'h100, 0, 32'h0,        0,   32'h0,        0,   1,  32'h0,        1,  1,  0,  0};
    vecs[2]  = '{32'h188, 0, 32'h0,        0,   32'h0,        0,   2,  32'h1,        1,  0,  0,  0};
    vecs[3]  = '{32'h004, 1, 32'h55,       3,   32'hDEADBEEF, 1,   5,  32'hDEADBEEF, 1,  1,  4,  0};
    vecs[4]  = '{32'h000, 0, 32'h0,        255, 32'hFFFFFFFF, 0,   9,  32'h0,        1,  1,  8,  0};
    vecs[5]  = '{32'h000, 0, 32'h0,        7,   32'hA5A50001, 0,   9,  32'hA5A50001, 1,  0,  8,  0};
    vecs[6]  = '{32'h188, 0, 32'h0,        0,   32'h0,        0,   2,  32'h2,        1,  0,  0,  0};
    vecs[7]  = '{32'h280, 0, 32'h0,        2,   32'h0BADF00D, 0,   4,  32'h0BADF00D, 1,  0,  0,  3};
    vecs[8]  = '{32'h18C, 1, 32'hFFFFFFFF, 0,   32'h0,        0,   2,  32'h0,        0,  0,  0,  0};
    vecs[9]  = '{32'h18C, 0, 32'h0,        0,   32'h0,        0,   2,  32'h0,        1,  0,  0,  0};
    vecs[10] = '{32'h184, 1, 32'hFFFFFFFE, 0,   32'h0,        0,   2,  32'h0,        0,  0,  0,  0};
    vecs[11] = '{32'h184, 0, 32'h0,        0,   32'h0,        0,   2,  32'h2,        1,  0,  0,  0};
    vecs[12] = '{32'h1B8, 0, 32'h0,        0,   32'h0,        0,   2,  32'h2,        1,  0,  0,  0};
    vecs[13] = '{32'h300, 0, 32'h0,        0,   32'h0,        0,   1,  32'h0,        1,  1,  0,  0};
    vecs[14] = '{32'h188, 0, 32'h0,        0,   32'h0,        0,   2,  32'h3,        1,  0,  0,  0};
    vecs[15] = '{32'h184, 1, 32'h3,        0,   32'h0,        0,   2,  32'h0,        0,  0,  0,  0};

    rst_i = 1'b1;
    req   = '0;
    intr  = '0;
    t_dly = 0;
    t_rd  = '0;
    t_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("reset_tgt_idle", 64'(tgt_req_o == '0), 64'h1);
    chk("reset_rsp", 64'(reg_rsp_o), 64'h0);
    chk("reset_intr", 64'(intr_o), 64'h0);

    for (int i = 0; i < 16; i++) begin
      t_dly = vecs[i].dly;
      t_rd  = vecs[i].trd;
      t_err = vecs[i].terr;
      access(vecs[i].addr, vecs[i].wr, vecs[i].wd, rd, er, lat, tv0, tv1);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_err", i), 64'(er), 64'(vecs[i].err));
      if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(vecs[i].rd));
      chk($sformatf("v%0d_tv0", i), 64'(tv0), 64'(vecs[i].tv0));
      chk($sformatf("v%0d_tv1", i), 64'(tv1), 64'(vecs[i].tv1));
    end

    // Interrupt edge with mask=3: intr_o rises two cycles after the edge cycle.
    @(posedge clk); #1 intr = 2'b01;
    @(negedge clk); chk("intr_e0", 64'(intr_o), 64'h0);
    @(posedge clk); #1 intr = 2'b00;
    @(negedge clk); chk("intr_e1", 64'(intr_o), 64'h0);
    @(negedge clk); chk("intr_e2", 64'(intr_o), 64'h1);
    rd_local("pending_after_edge", 32'h180, 32'h1);

    // W1C in the same cycle as a fresh edge: the set must win.
    @(posedge clk); #1;
    req = '{addr: 32'h180, write: 1'b1, wdata: 32'h1, wstrb: 4'hf, valid: 1'b1};
    @(posedge clk); #1 intr = 2'b01;
    @(negedge clk); chk("w1c_local_ready", 64'(reg_rsp_o.ready), 64'h0);
    @(posedge clk); #1 intr = 2'b00;
    @(negedge clk); chk("w1c_resp_ready", 64'(reg_rsp_o.ready), 64'h1);
    @(posedge clk); #1 req = '0;
    rd_local("pending_set_wins", 32'h180, 32'h1);
    chk("intr_still_high", 64'(intr_o), 64'h1);

    wr_local(32'h180, 32'h1);
    rd_local("pending_cleared", 32'h180, 32'h0);
    chk("intr_low_after_clear", 64'(intr_o), 64'h0);

    // Masked source: pending sets but intr_o only follows once the mask allows it.
    wr_local(32'h184, 32'h1);
    @(posedge clk); #1 intr = 2'b10;
    @(posedge clk); #1 intr = 2'b00;
    repeat (3) @(negedge clk);
    chk("intr_masked", 64'(intr_o), 64'h0);
    rd_local("pending_masked", 32'h180, 32'h2);
    wr_local(32'h184, 32'h3);
    repeat (2) @(negedge clk);
    chk("intr_unmasked", 64'(intr_o), 64'h1);

    // 18 decode errors saturate the 4-bit counter at 15.
    for (int i = 0; i < 18; i++) begin
      access(32'h100, 1'b0, 32'h0, rd, er, lat, tv0, tv1);
    end
    chk("sat_last_err", 64'(er), 64'h1);
    rd_local("err_saturated", 32'h188, 32'hF);
    wr_local(32'h188, 32'h0);
    rd_local("err_cleared", 32'h188, 32'h0);

    // Reset while a forwarded access is stalled.
    t_dly = 255;
    @(posedge clk); #1;
    req = '{addr: 32'h000, write: 1'b0, wdata: 32'h0, wstrb: 4'hf, valid: 1'b1};
    @(negedge clk);
    @(negedge clk); chk("fwd_valid_before_rst", 64'(tgt_req_o[0].valid), 64'h1);
    @(posedge clk); #1 begin rst_i = 1'b1; req = '0; end
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_tgt_idle", 64'(tgt_req_o == '0), 64'h1);
    chk("rst_rsp_zero", 64'(reg_rsp_o), 64'h0);
    chk("rst_intr", 64'(intr_o), 64'h0);
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (reg_rsp_o.ready || tgt_req_o[0].valid) lat++;
    end
    chk("rst_no_activity", 64'(lat), 64'h0);
    rd_local("rst_mask", 32'h184, 32'h0);
    rd_local("rst_pending", 32'h180, 32'h0);

    t_dly = 0;
    t_rd  = 32'h12345678;
    t_err = 1'b0;
    access(32'h080, 1'b0, 32'h0, rd, er, lat, tv0, tv1);
    chk("post_rst_lat", 64'(lat), 64'h2);
    chk("post_rst_rdata", 64'(rd), 64'h12345678);
    chk("post_rst_err", 64'(er), 64'h0);
    chk("post_rst_tv1", 64'(tv1), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
